// File: rtl/shared_fn_sched.sv
// rtl/shared_fn_sched.sv - round-robin scheduler sharing one multi-cycle function unit
// Optional timeout watchdog in WAIT is compiled in with SHARED_FN_SCHED_WATCHDOG_EN.
module shared_fn_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_arg1,
  input  logic [NUM_REQ*DATA_W-1:0] req_arg2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fn_valid,
  input  logic                      fn_ready,
  output logic [DATA_W-1:0]         fn_arg1,
  output logic [DATA_W-1:0]         fn_arg2,
  input  logic                      fn_res_valid,
  input  logic [DATA_W-1:0]         fn_res,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("shared_fn_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_nx;
  logic             any_req;
  logic [DATA_W-1:0] res_q;

`ifdef SHARED_FN_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_q;

  // A result on the limit cycle wins over the timeout.
  assign tmo_hit = (state == WAIT) && !fn_res_valid &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign any_req = |req_valid;

  // Lowest offset from rr_ptr wins, so scan offsets downward and keep the last hit.
  always_comb begin
    int               sum;
    logic [IDX_W-1:0] cand;
    sum    = 0;
    cand   = '0;
    gnt_nx = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (req_valid[cand]) gnt_nx = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (any_req) state_nx = ISSUE;
      ISSUE: if (fn_ready) state_nx = WAIT;
      WAIT: begin
        if (fn_res_valid) state_nx = RESP;
`ifdef SHARED_FN_SCHED_WATCHDOG_EN
        else if (tmo_hit) state_nx = RESP;
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_arg1 <= '0;
      fn_arg2 <= '0;
      gnt_q   <= '0;
      rr_ptr  <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            fn_arg1 <= req_arg1[int'(gnt_nx)*DATA_W +: DATA_W];
            fn_arg2 <= req_arg2[int'(gnt_nx)*DATA_W +: DATA_W];
            gnt_q   <= gnt_nx;
          end
        end
        WAIT: begin
          if (fn_res_valid) res_q <= fn_res;
`ifdef SHARED_FN_SCHED_WATCHDOG_EN
          else if (tmo_hit) res_q <= '0;
`endif
        end
        RESP: begin
          if (gnt_q == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                              rr_ptr <= gnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHARED_FN_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != WAIT)     tmo_cnt <= '0;
      else if (!fn_res_valid) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == WAIT) begin
        if (fn_res_valid) err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    fn_valid  = (state == ISSUE);
    busy      = (state != IDLE);
    if (state == IDLE && any_req) req_ready[gnt_nx] = 1'b1;
    if (state == RESP) begin
      rsp_valid[gnt_q] = 1'b1;
      rsp_data         = res_q;
`ifdef SHARED_FN_SCHED_WATCHDOG_EN
      rsp_err          = err_q;
`endif
    end
  end

endmodule

// File: tb/tb_shared_fn_sched.sv
// tb/tb_shared_fn_sched.sv - scoreboard bench for shared_fn_sched
// Watchdog cases run when SHARED_FN_SCHED_WATCHDOG_EN is defined.
module tb_shared_fn_sched;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_arg1 = '0;
  logic [N*W-1:0] req_arg2 = '0;
  logic [N-1:0]   req_ready;
  logic           fn_valid;
  logic           fn_ready = 1'b0;
  logic [W-1:0]   fn_arg1;
  logic [W-1:0]   fn_arg2;
  logic           fn_res_valid = 1'b0;
  logic [W-1:0]   fn_res = '0;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  shared_fn_sched #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_arg1(req_arg1), .req_arg2(req_arg2), .req_ready(req_ready),
    .fn_valid(fn_valid), .fn_ready(fn_ready), .fn_arg1(fn_arg1), .fn_arg2(fn_arg2),
    .fn_res_valid(fn_res_valid), .fn_res(fn_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] d;
    logic         e;
    int           c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", W'(rsp_valid), '0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", W'(rsp_valid), W'(mon_e.v));
        check("rsp_data", rsp_data, mon_e.d);
        check("rsp_err", W'(rsp_err), W'(mon_e.e));
        check("rsp_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle; returns in the next IDLE cycle with req_valid still driven.
  // stall = extra ISSUE cycles, wdel = extra WAIT cycles before the result (or timeout).
  task automatic run_call(input logic [N-1:0] rv, input int g,
                          input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W-1:0] r,
                          input int stall, input int wdel, input bit stray, input bit exp_err);
    exp_t e;
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_arg1[i*W +: W] = (i == g) ? a1 : W'(32'hdead_0000 + i);
      req_arg2[i*W +: W] = (i == g) ? a2 : W'(32'hbeef_0000 + i);
    end
    fn_ready     = 1'b0;
    fn_res_valid = stray;
    fn_res       = 32'd99;
    #1;
    check("req_ready", W'(req_ready), 1 << g);
    check("busy_idle", W'(busy), 0);
    e.v = N'(1 << g);
    e.d = exp_err ? '0 : r;
    e.e = exp_err;
    e.c = cyc + 3 + stall + wdel;
    sb.push_back(e);
    tick();
    fn_res_valid = stray;
    fn_ready     = (stall == 0);
    #1;
    check("fn_valid_issue", W'(fn_valid), 1);
    check("fn_arg1", fn_arg1, a1);
    check("fn_arg2", fn_arg2, a2);
    check("req_ready_busy", W'(req_ready), 0);
    for (int k = 1; k <= stall; k++) begin
      tick();
      fn_res_valid = 1'b0;
      fn_ready     = (k == stall);
      #1;
      check("fn_valid_stall", W'(fn_valid), 1);
      check("fn_arg1_stable", fn_arg1, a1);
      check("fn_arg2_stable", fn_arg2, a2);
    end
    for (int k = 0; k <= wdel; k++) begin
      tick();
      fn_ready     = 1'b0;
      fn_res_valid = (k == wdel) && !exp_err;
      fn_res       = r;
      #1;
      check("fn_valid_wait", W'(fn_valid), 0);
      check("busy_wait", W'(busy), 1);
    end
    tick();
    fn_res_valid = exp_err;
    fn_res       = r;
    #1;
    check("busy_resp", W'(busy), 1);
    tick();
    fn_res_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    #1;
    check("rst_req_ready", W'(req_ready), 0);
    check("rst_rsp_valid", W'(rsp_valid), 0);
    check("rst_fn_valid", W'(fn_valid), 0);
    check("rst_fn_arg1", fn_arg1, 0);
    check("rst_fn_arg2", fn_arg2, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", W'(rsp_err), 0);
    check("rst_busy", W'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_call(4'b0100, 2, 32'd5, 32'd7, 32'd12, 0, 0, 1'b0, 1'b0);
    run_call(4'b1001, 3, -32'sd20, 32'd4, -32'sd16, 0, 0, 1'b0, 1'b0);
    run_call(4'b1111, 0, 32'd1, 32'd2, 32'd3, 0, 0, 1'b0, 1'b0);
    run_call(4'b1111, 1, 32'd10, 32'd20, 32'd30, 0, 0, 1'b0, 1'b0);
    run_call(4'b1111, 2, 32'd100, -32'sd1, 32'd99, 0, 0, 1'b0, 1'b0);
    run_call(4'b1111, 3, 32'h1000, 32'h0234, 32'h1234, 0, 0, 1'b0, 1'b0);
    run_call(4'b1111, 0, 32'd6, 32'd6, 32'd12, 0, 0, 1'b0, 1'b0);
    run_call(4'b0100, 2, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff, 5, 0, 1'b0, 1'b0);
    run_call(4'b0011, 0, 32'd100, 32'd23, 32'd123, 0, 0, 1'b1, 1'b0);
    run_call(4'b0010, 1, 32'd40, 32'd2, 32'd42, 1, 3, 1'b0, 1'b0);
`ifdef SHARED_FN_SCHED_WATCHDOG_EN
    run_call(4'b1000, 3, 32'd6, 32'd6, 32'd12, 0, 3, 1'b0, 1'b1);
    run_call(4'b0001, 0, 32'd8, 32'd9, 32'd17, 0, 3, 1'b0, 1'b0);
`endif

    req_valid          = 4'b0010;
    req_arg1[1*W +: W] = 32'h0000_0a0a;
    req_arg2[1*W +: W] = 32'h0000_0b0b;
    #1;
    check("mid_req_ready", W'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    fn_ready  = 1'b1;
    #1;
    check("mid_fn_valid", W'(fn_valid), 1);
    tick();
    fn_ready = 1'b0;
    #1;
    check("mid_busy_wait", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_fn_valid", W'(fn_valid), 0);
    check("mid_rst_fn_arg1", fn_arg1, 0);
    check("mid_rst_fn_arg2", fn_arg2, 0);
    check("mid_rst_rsp", W'(rsp_valid), 0);
    tick();
    fn_res_valid = 1'b1;
    fn_res       = 32'd77;
    tick();
    fn_res_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    run_call(4'b1111, 0, 32'd3, 32'd4, 32'd7, 0, 0, 1'b0, 1'b0);
    req_valid = '0;

    repeat (4) tick();
    check("rsp_pending", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
